// File: rtl/mac_pause_pkg.sv
// Shared definitions for the 802.3x pause path: FSM states, default widths,
// and pause-frame constants also used by the RX pause decoder.
package mac_pause_pkg;

    localparam int unsigned QUANTA_W_DEF = 16;
    localparam int unsigned SUBQ_W_DEF   = 8;
    localparam int unsigned AXIS_DATA_W  = 64;
    localparam int unsigned AXIS_KEEP_W  = AXIS_DATA_W / 8;
    localparam int unsigned HELD_CNT_W   = 32;

    // MAC control frame identification
    localparam logic [47:0] PAUSE_DA        = 48'h0180_C200_0001;
    localparam logic [15:0] PAUSE_ETHERTYPE = 16'h8808;
    localparam logic [15:0] PAUSE_OPCODE    = 16'h0001;
    localparam int unsigned PAUSE_QUANTUM_BITS = 512;

    typedef enum logic [1:0] {
        PASS  = 2'd0,
        FRAME = 2'd1,
        HOLD  = 2'd2
    } pause_state_e;

    typedef struct packed {
        logic [AXIS_DATA_W-1:0] tdata;
        logic [AXIS_KEEP_W-1:0] tkeep;
        logic                   tlast;
    } axis_beat_t;

endpackage

// File: rtl/pause_quanta_timer.sv
// Pause quanta countdown: qcnt counts quanta, scnt prescales clk cycles into
// quanta. Loads on a request, cleared while pause is disabled.
module pause_quanta_timer
    import mac_pause_pkg::*;
#(
    parameter int unsigned QUANTA_W = QUANTA_W_DEF,
    parameter int unsigned SUBQ_W   = SUBQ_W_DEF
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic                cfg_pause_enable,
    input  logic [SUBQ_W-1:0]   cfg_sub_quanta_count,
    input  logic                pause_req_valid,
    input  logic [QUANTA_W-1:0] pause_req_quanta,
    output logic [QUANTA_W-1:0] qcnt,
    output logic                pause_active
);

    logic [QUANTA_W-1:0] r_qcnt;
    logic [QUANTA_W-1:0] w_qcnt_nxt;
    logic [SUBQ_W-1:0]   r_scnt;
    logic [SUBQ_W-1:0]   w_scnt_nxt;
    logic [SUBQ_W-1:0]   w_sub_max;
    logic                r_active;

    // A prescale of 0 behaves as 1 cycle per quantum
    assign w_sub_max = (cfg_sub_quanta_count == '0) ? '0
                                                    : cfg_sub_quanta_count - SUBQ_W'(1);

    always_comb begin
        w_qcnt_nxt = r_qcnt;
        w_scnt_nxt = r_scnt;
        if (!cfg_pause_enable) begin
            w_qcnt_nxt = '0;
            w_scnt_nxt = '0;
        end else if (pause_req_valid) begin
            w_qcnt_nxt = pause_req_quanta;
            w_scnt_nxt = '0;
        end else if (r_qcnt != '0) begin
            if (r_scnt == w_sub_max) begin
                w_scnt_nxt = '0;
                w_qcnt_nxt = r_qcnt - QUANTA_W'(1);
            end else begin
                w_scnt_nxt = r_scnt + SUBQ_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_qcnt   <= '0;
            r_scnt   <= '0;
            r_active <= 1'b0;
        end else begin
            r_qcnt   <= w_qcnt_nxt;
            r_scnt   <= w_scnt_nxt;
            r_active <= (w_qcnt_nxt != '0);
        end
    end

    assign qcnt         = r_qcnt;
    assign pause_active = r_active;

endmodule

// File: rtl/tx_pause_ctrl.sv
// TX pause scheduler: gates new frame starts on the user TX AXI4-Stream while
// the pause timer runs; frames already in flight always complete.
module tx_pause_ctrl
    import mac_pause_pkg::*;
#(
    parameter int unsigned QUANTA_W = QUANTA_W_DEF,
    parameter int unsigned SUBQ_W   = SUBQ_W_DEF
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   cfg_pause_enable,
    input  logic [SUBQ_W-1:0]      cfg_sub_quanta_count,
    input  logic                   pause_req_valid,
    input  logic [QUANTA_W-1:0]    pause_req_quanta,
    input  logic [AXIS_DATA_W-1:0] s_axis_tdata,
    input  logic [AXIS_KEEP_W-1:0] s_axis_tkeep,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic [AXIS_DATA_W-1:0] m_axis_tdata,
    output logic [AXIS_KEEP_W-1:0] m_axis_tkeep,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic                   pause_active,
    output logic [QUANTA_W-1:0]    pause_quanta_remaining,
    output logic [HELD_CNT_W-1:0]  held_frames
);

    pause_state_e          r_state;
    pause_state_e          w_state_nxt;
    logic [QUANTA_W-1:0]   w_qcnt;
    logic                  w_qcnt_zero;
    logic                  w_gate_open;
    logic                  w_accept;
    logic                  w_held_inc;
    logic [HELD_CNT_W-1:0] r_held_frames;
    axis_beat_t            w_beat;

    pause_quanta_timer #(
        .QUANTA_W (QUANTA_W),
        .SUBQ_W   (SUBQ_W)
    ) u_timer (
        .clk                  (clk),
        .aresetn              (aresetn),
        .cfg_pause_enable     (cfg_pause_enable),
        .cfg_sub_quanta_count (cfg_sub_quanta_count),
        .pause_req_valid      (pause_req_valid),
        .pause_req_quanta     (pause_req_quanta),
        .qcnt                 (w_qcnt),
        .pause_active         (pause_active)
    );

    // Open frames are never gated, so valid is never withdrawn mid-frame
    assign w_qcnt_zero = (w_qcnt == '0);
    assign w_gate_open = (r_state == FRAME) | w_qcnt_zero;
    assign w_accept    = s_axis_tvalid & m_axis_tready & w_gate_open;

    assign w_beat        = '{tdata: s_axis_tdata, tkeep: s_axis_tkeep, tlast: s_axis_tlast};
    assign m_axis_tdata  = w_beat.tdata;
    assign m_axis_tkeep  = w_beat.tkeep;
    assign m_axis_tlast  = w_beat.tlast;
    assign m_axis_tvalid = s_axis_tvalid & w_gate_open;
    assign s_axis_tready = m_axis_tready & w_gate_open;

    always_comb begin
        w_state_nxt = r_state;
        w_held_inc  = 1'b0;
        unique case (r_state)
            PASS: begin
                if (s_axis_tvalid && !w_qcnt_zero) begin
                    w_state_nxt = HOLD;
                    w_held_inc  = 1'b1;
                end else if (w_accept && !s_axis_tlast) begin
                    w_state_nxt = FRAME;
                end
            end
            FRAME: begin
                if (w_accept && s_axis_tlast) begin
                    w_state_nxt = PASS;
                end
            end
            HOLD: begin
                if (w_accept) begin
                    w_state_nxt = s_axis_tlast ? PASS : FRAME;
                end
            end
            default: w_state_nxt = PASS;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= PASS;
            r_held_frames <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_held_inc) begin
                r_held_frames <= r_held_frames + HELD_CNT_W'(1);
            end
        end
    end

    assign pause_quanta_remaining = w_qcnt;
    assign held_frames            = r_held_frames;

endmodule

// File: tb/tb_tx_pause_ctrl.sv
// Bench for tx_pause_ctrl: vector table, directed pause corner cases, and a
// randomized run against a cycle-count reference model.
module tb_tx_pause_ctrl;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        cfg_pause_enable;
    logic [7:0]  cfg_sub_quanta_count;
    logic        pause_req_valid;
    logic [15:0] pause_req_quanta;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        pause_active;
    logic [15:0] pause_quanta_remaining;
    logic [31:0] held_frames;

    int n_vec = 0;
    int n_err = 0;

    tx_pause_ctrl dut (
        .clk                    (clk),
        .aresetn                (aresetn),
        .cfg_pause_enable       (cfg_pause_enable),
        .cfg_sub_quanta_count   (cfg_sub_quanta_count),
        .pause_req_valid        (pause_req_valid),
        .pause_req_quanta       (pause_req_quanta),
        .s_axis_tdata           (s_axis_tdata),
        .s_axis_tkeep           (s_axis_tkeep),
        .s_axis_tvalid          (s_axis_tvalid),
        .s_axis_tlast           (s_axis_tlast),
        .s_axis_tready          (s_axis_tready),
        .m_axis_tdata           (m_axis_tdata),
        .m_axis_tkeep           (m_axis_tkeep),
        .m_axis_tvalid          (m_axis_tvalid),
        .m_axis_tlast           (m_axis_tlast),
        .m_axis_tready          (m_axis_tready),
        .pause_active           (pause_active),
        .pause_quanta_remaining (pause_quanta_remaining),
        .held_frames            (held_frames)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        rv;
        logic [15:0] rq;
        logic        tv;
        logic        tl;
        logic        mr;
        logic        x_sr;
        logic        x_mv;
        logic        x_act;
        logic [15:0] x_rem;
        logic [31:0] x_held;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(input logic en, input logic rv, input logic [15:0] rq,
                                input logic tv, input logic tl, input logic mr,
                                input logic xs, input logic xm, input logic xa,
                                input logic [15:0] xr, input logic [31:0] xh);
        vec_t v;
        v.en = en; v.rv = rv; v.rq = rq; v.tv = tv; v.tl = tl; v.mr = mr;
        v.x_sr = xs; v.x_mv = xm; v.x_act = xa; v.x_rem = xr; v.x_held = xh;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        aresetn              = 1'b0;
        cfg_pause_enable     = 1'b1;
        pause_req_valid      = 1'b0;
        pause_req_quanta     = 16'd0;
        s_axis_tvalid        = 1'b0;
        s_axis_tlast         = 1'b0;
        s_axis_tdata         = 64'd0;
        s_axis_tkeep         = 8'd0;
        m_axis_tready        = 1'b1;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
    endtask

    task automatic new_beat();
        s_axis_tdata = {$urandom, $urandom};
        s_axis_tkeep = 8'($urandom);
    endtask

    // Watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    // Reference model state: pause measured in remaining clk cycles
    int          m_left;
    int          s_eff;
    bit          m_inf;
    bit          m_hold;
    int unsigned m_held;
    bit          gate;
    bit          acc_m;
    bit          prev_acc;
    bit          src_valid;
    int          src_left;
    int          gap;
    int          n_in;
    int          n_out;
    int          cnt;

    initial begin
        tbl[0]  = mk(H, L, 16'd0, L, L, H,  H, L, L, 16'd0, 32'd0);
        tbl[1]  = mk(H, H, 16'd2, L, L, H,  H, L, L, 16'd0, 32'd0);
        tbl[2]  = mk(H, L, 16'd0, H, L, H,  L, L, H, 16'd2, 32'd0);
        tbl[3]  = mk(H, L, 16'd0, H, L, H,  L, L, H, 16'd2, 32'd1);
        tbl[4]  = mk(H, L, 16'd0, H, L, H,  L, L, H, 16'd1, 32'd1);
        tbl[5]  = mk(H, L, 16'd0, H, L, H,  L, L, H, 16'd1, 32'd1);
        tbl[6]  = mk(H, L, 16'd0, H, L, H,  H, H, L, 16'd0, 32'd1);
        tbl[7]  = mk(H, H, 16'd3, H, L, H,  H, H, L, 16'd0, 32'd1);
        tbl[8]  = mk(H, L, 16'd0, H, H, L,  L, H, H, 16'd3, 32'd1);
        tbl[9]  = mk(H, L, 16'd0, H, H, H,  H, H, H, 16'd3, 32'd1);
        tbl[10] = mk(H, L, 16'd0, H, H, H,  L, L, H, 16'd2, 32'd1);
        tbl[11] = mk(H, H, 16'd0, H, H, H,  L, L, H, 16'd2, 32'd2);
        tbl[12] = mk(H, L, 16'd0, H, H, H,  H, H, L, 16'd0, 32'd2);
        tbl[13] = mk(L, H, 16'd5, L, L, H,  H, L, L, 16'd0, 32'd2);
        tbl[14] = mk(L, L, 16'd0, H, H, H,  H, H, L, 16'd0, 32'd2);

        // Reset state, with a beat offered during reset
        cfg_sub_quanta_count = 8'd2;
        do_reset();
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b1;
        #1;
        chk("rst_active", 64'(pause_active), 64'(1'b0));
        chk("rst_rem", 64'(pause_quanta_remaining), 64'd0);
        chk("rst_held", 64'(held_frames), 64'd0);
        chk("rst_mvalid", 64'(m_axis_tvalid), 64'(1'b1));
        chk("rst_sready", 64'(s_axis_tready), 64'(1'b1));

        // Vector table, S=2
        do_reset();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            cfg_pause_enable = tbl[i].en;
            pause_req_valid  = tbl[i].rv;
            pause_req_quanta = tbl[i].rq;
            s_axis_tvalid    = tbl[i].tv;
            s_axis_tlast     = tbl[i].tl;
            m_axis_tready    = tbl[i].mr;
            s_axis_tdata     = 64'(i) * 64'h0101_0101_0101_0101;
            #1;
            chk($sformatf("tbl%0d_sready", i), 64'(s_axis_tready), 64'(tbl[i].x_sr));
            chk($sformatf("tbl%0d_mvalid", i), 64'(m_axis_tvalid), 64'(tbl[i].x_mv));
            chk($sformatf("tbl%0d_active", i), 64'(pause_active), 64'(tbl[i].x_act));
            chk($sformatf("tbl%0d_rem", i), 64'(pause_quanta_remaining), 64'(tbl[i].x_rem));
            chk($sformatf("tbl%0d_held", i), 64'(held_frames), 64'(tbl[i].x_held));
            chk($sformatf("tbl%0d_tdata", i), m_axis_tdata, s_axis_tdata);
        end

        // S=4, Q=3 while idle: 12 blocked cycles after the strobe cycle
        do_reset();
        cfg_sub_quanta_count = 8'd4;
        @(negedge clk);
        pause_req_valid  = 1'b1;
        pause_req_quanta = 16'd3;
        @(negedge clk);
        pause_req_valid = 1'b0;
        s_axis_tvalid   = 1'b1;
        s_axis_tlast    = 1'b1;
        #1;
        cnt = 0;
        while (!s_axis_tready && cnt < 50) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        chk("q3s4_blocked_cycles", 64'(cnt), 64'd12);
        chk("q3s4_held", 64'(held_frames), 64'd1);
        @(negedge clk);
        s_axis_tvalid = 1'b0;

        // Request on beat 2 of an 8-beat frame: frame completes, next frame held
        do_reset();
        cfg_sub_quanta_count = 8'd4;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            s_axis_tvalid    = 1'b1;
            s_axis_tlast     = (k == 7);
            pause_req_valid  = (k == 1);
            pause_req_quanta = 16'd5;
            #1;
            chk($sformatf("midframe_beat%0d_ready", k), 64'(s_axis_tready), 64'(1'b1));
        end
        @(negedge clk);
        pause_req_valid = 1'b0;
        s_axis_tlast    = 1'b1;
        #1;
        cnt = 0;
        while (!s_axis_tready && cnt < 50) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        chk("midframe_next_blocked", 64'(cnt), 64'd14);
        chk("midframe_held", 64'(held_frames), 64'd1);
        @(negedge clk);
        s_axis_tvalid = 1'b0;

        // Q=100 then Q=0 twenty cycles later cancels the pause
        do_reset();
        cfg_sub_quanta_count = 8'd1;
        @(negedge clk);
        pause_req_valid  = 1'b1;
        pause_req_quanta = 16'd100;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            pause_req_valid = 1'b0;
            s_axis_tvalid   = 1'b1;
            s_axis_tlast    = 1'b1;
        end
        #1;
        chk("cancel_pre_sready", 64'(s_axis_tready), 64'(1'b0));
        chk("cancel_pre_active", 64'(pause_active), 64'(1'b1));
        @(negedge clk);
        pause_req_valid  = 1'b1;
        pause_req_quanta = 16'd0;
        #1;
        chk("cancel_strobe_active", 64'(pause_active), 64'(1'b1));
        @(negedge clk);
        pause_req_valid = 1'b0;
        #1;
        chk("cancel_post_active", 64'(pause_active), 64'(1'b0));
        chk("cancel_post_sready", 64'(s_axis_tready), 64'(1'b1));
        chk("cancel_post_mvalid", 64'(m_axis_tvalid), 64'(1'b1));
        @(negedge clk);
        s_axis_tvalid = 1'b0;

        // Disabled pause ignores requests; dropping enable clears the timer
        do_reset();
        cfg_sub_quanta_count = 8'd2;
        cfg_pause_enable     = 1'b0;
        @(negedge clk);
        pause_req_valid  = 1'b1;
        pause_req_quanta = 16'd50;
        @(negedge clk);
        pause_req_valid = 1'b0;
        s_axis_tvalid   = 1'b1;
        s_axis_tlast    = 1'b1;
        #1;
        chk("dis_active", 64'(pause_active), 64'(1'b0));
        chk("dis_rem", 64'(pause_quanta_remaining), 64'd0);
        chk("dis_sready", 64'(s_axis_tready), 64'(1'b1));
        @(negedge clk);
        s_axis_tvalid    = 1'b0;
        cfg_pause_enable = 1'b1;
        pause_req_valid  = 1'b1;
        #1;
        chk("dis_held", 64'(held_frames), 64'd0);
        @(negedge clk);
        pause_req_valid = 1'b0;
        #1;
        chk("en_active", 64'(pause_active), 64'(1'b1));
        chk("en_rem", 64'(pause_quanta_remaining), 64'd50);
        @(negedge clk);
        cfg_pause_enable = 1'b0;
        @(negedge clk);
        cfg_pause_enable = 1'b1;
        #1;
        chk("drop_en_active", 64'(pause_active), 64'(1'b0));
        chk("drop_en_rem", 64'(pause_quanta_remaining), 64'd0);

        // Asynchronous reset while holding a frame with qcnt=40
        do_reset();
        cfg_sub_quanta_count = 8'd2;
        @(negedge clk);
        pause_req_valid  = 1'b1;
        pause_req_quanta = 16'd40;
        @(negedge clk);
        pause_req_valid = 1'b0;
        s_axis_tvalid   = 1'b1;
        s_axis_tlast    = 1'b0;
        @(negedge clk);
        #1;
        chk("hold_rem40", 64'(pause_quanta_remaining), 64'd40);
        chk("hold_held", 64'(held_frames), 64'd1);
        chk("hold_sready", 64'(s_axis_tready), 64'(1'b0));
        #1;
        aresetn = 1'b0;
        #1;
        chk("arst_active", 64'(pause_active), 64'(1'b0));
        chk("arst_rem", 64'(pause_quanta_remaining), 64'd0);
        chk("arst_held", 64'(held_frames), 64'd0);
        chk("arst_mvalid", 64'(m_axis_tvalid), 64'(1'b1));
        chk("arst_sready", 64'(s_axis_tready), 64'(1'b1));
        @(negedge clk);
        aresetn      = 1'b1;
        s_axis_tlast = 1'b1;
        #1;
        chk("arst_release_sready", 64'(s_axis_tready), 64'(1'b1));
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        #1;
        chk("arst_release_held", 64'(held_frames), 64'd0);

        // Randomized traffic and requests against the cycle-count model
        for (int ph = 0; ph < 4; ph++) begin
            cfg_sub_quanta_count = 8'(ph);
            do_reset();
            s_eff     = (ph == 0) ? 1 : ph;
            m_left    = 0;
            m_inf     = 1'b0;
            m_hold    = 1'b0;
            m_held    = 0;
            src_valid = 1'b0;
            src_left  = 0;
            gap       = 0;
            prev_acc  = 1'b0;
            n_in      = 0;
            n_out     = 0;
            for (int c = 0; c < 800; c++) begin
                @(negedge clk);
                if (prev_acc) begin
                    src_left--;
                    if (src_left == 0) begin
                        src_valid = 1'b0;
                        gap       = int'($urandom_range(0, 3));
                    end else begin
                        new_beat();
                    end
                end
                if (!src_valid) begin
                    if (gap > 0) begin
                        gap--;
                    end else begin
                        src_valid = 1'b1;
                        src_left  = int'($urandom_range(1, 8));
                        new_beat();
                    end
                end
                s_axis_tvalid    = src_valid;
                s_axis_tlast     = (src_left == 1);
                m_axis_tready    = ($urandom_range(0, 3) != 0);
                pause_req_valid  = ($urandom_range(0, 29) == 0);
                pause_req_quanta = 16'($urandom_range(0, 6));
                cfg_pause_enable = ($urandom_range(0, 149) != 0);
                #1;
                gate = m_inf || (m_left == 0);
                chk("rnd_sready", 64'(s_axis_tready), 64'(m_axis_tready && gate));
                chk("rnd_mvalid", 64'(m_axis_tvalid), 64'(s_axis_tvalid && gate));
                chk("rnd_active", 64'(pause_active), 64'(m_left != 0));
                chk("rnd_rem", 64'(pause_quanta_remaining), 64'((m_left + s_eff - 1) / s_eff));
                chk("rnd_held", 64'(held_frames), 64'(m_held));
                if (m_axis_tvalid) begin
                    chk("rnd_tdata", m_axis_tdata, s_axis_tdata);
                    chk("rnd_tkeep", 64'(m_axis_tkeep), 64'(s_axis_tkeep));
                    chk("rnd_tlast", 64'(m_axis_tlast), 64'(s_axis_tlast));
                end
                prev_acc = s_axis_tvalid && s_axis_tready;
                if (m_axis_tvalid && m_axis_tready) n_out++;
                acc_m = s_axis_tvalid && m_axis_tready && gate;
                if (acc_m) n_in++;
                if (!m_inf && !m_hold && s_axis_tvalid && m_left != 0) begin
                    m_hold = 1'b1;
                    m_held++;
                end else if (acc_m) begin
                    m_inf  = !s_axis_tlast;
                    m_hold = 1'b0;
                end
                if (!cfg_pause_enable) m_left = 0;
                else if (pause_req_valid) m_left = int'(pause_req_quanta) * s_eff;
                else if (m_left > 0) m_left--;
            end
            chk($sformatf("rnd_ph%0d_beats", ph), 64'(n_out), 64'(n_in));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tx_pause_ctrl.md
# tx_pause_ctrl

Transmit-side 802.3x pause scheduler for the 10G MAC. Takes decoded pause requests from the RX pause path and runs the quanta countdown timer. Gates the user TX AXI4-Stream into the TX framer so that a pause never truncates a frame: only new frame starts are held. Sits between the user TX AXIS interface and the `tx` datapath.

## Interface
- `QUANTA_W`, 16, pause quanta field width
- `SUBQ_W`, 8, sub-quanta prescaler width
- `clk` in 1 — MAC core clock; all logic single-clock
- `aresetn` in 1 — reset, asynchronous, active-low
- `cfg_pause_enable` in 1 — honour pause requests; low clears timer
- `cfg_sub_quanta_count` in SUBQ_W — clk cycles per quanta; 0 treated as 1
- `pause_req_valid` in 1 — one-cycle strobe: new pause request decoded
- `pause_req_quanta` in QUANTA_W — requested quanta, valid with strobe
- `s_axis_tdata/tkeep/tvalid/tlast` in 64/8/1/1 — user TX stream
- `s_axis_tready` out 1
- `m_axis_tdata/tkeep/tvalid/tlast` out 64/8/1/1 — to TX framer
- `m_axis_tready` in 1
- `pause_active` out 1 — timer nonzero
- `pause_quanta_remaining` out QUANTA_W — current timer value
- `held_frames` out 32 — count of frame starts delayed by pause

## Operation
- Timer register `qcnt`, prescaler `scnt`:
  - On `pause_req_valid && cfg_pause_enable`: `qcnt <= pause_req_quanta`, `scnt <= 0`. A new request overrides the old one in either direction; quanta 0 cancels.
  - Otherwise, if `qcnt != 0`: `scnt` increments. When `scnt == max(cfg,1)-1`, `scnt <= 0` and `qcnt <= qcnt-1`.
  - Load wins over a simultaneous decrement.
  - `cfg_pause_enable` low: `qcnt <= 0`, `scnt <= 0`, requests ignored.
- FSM `{PASS, FRAME, HOLD}`:
  - `PASS`: no frame open.
    - `s_axis_tvalid && qcnt != 0` → `HOLD`, incrementing `held_frames` once.
    - Accepted beat without `tlast` → `FRAME`.
    - Single-beat frame (`tlast`) → stays in `PASS`.
  - `FRAME`: gate forced open. Accepted beat with `tlast` → `PASS`.
  - `HOLD`: gate closed. When `qcnt == 0`, the gate reopens and the first accepted beat leaves `HOLD`: to `FRAME` if not `tlast`, to `PASS` if `tlast`.
- Gate: `gate_open = (state==FRAME) | (qcnt==0)`.
  - `m_axis_tvalid = s_axis_tvalid & gate_open`
  - `s_axis_tready = m_axis_tready & gate_open`
  - `tdata`, `tkeep` and `tlast` pass straight through.
  - The path is combinational, so AXIS rules hold: valid is never dropped by the block mid-frame.
- `held_frames` wraps at 2^32.
- `pause_active = (qcnt != 0)`; `pause_quanta_remaining = qcnt`.

## Timing
- Reset values:
  - `qcnt`, `scnt`, `held_frames` = 0; state = `PASS`.
  - `pause_active` = 0; `m_axis_tvalid` follows `s_axis_tvalid`.
- Request strobed at edge N: `pause_active` high from cycle N+1. A frame start at N+1 is held.
- Pause duration is exactly Q×S cycles, with S = max(cfg,1). `pause_active` drops and the gate opens at cycle N+1+Q×S.
- A request arriving while in `FRAME` has no effect on the current frame. The next frame start is held.
- A request with Q=0 at edge N reopens the gate at N+1.
- Reset asserted mid-frame or mid-pause: immediate return to reset values. The upstream frame is truncated and upstream must restart it.
- Zero added latency on the data path; no buffering.

## Structure
- Shared package `mac_pause_pkg`:
  - FSM state enum `{PASS, FRAME, HOLD}`.
  - `QUANTA_W` and `SUBQ_W` defaults.
  - Pause opcode/ethertype constants, shared with the RX pause decoder.
- One sub-module, `pause_quanta_timer`: holds `qcnt`/`scnt`, load/cancel/enable logic, and the `pause_active` output.
- The top level holds the FSM, the gate and `held_frames`.

## Test plan
- No requests, 3 back-to-back 64-byte frames with `m_axis_tready` toggled every other cycle → output beats and order identical to input, `held_frames`=0.
- cfg S=4, request Q=3 while idle with a frame pending → `s_axis_tready` low for 12 cycles after the strobe cycle, first beat accepted at N+13, `held_frames`=1.
- Request Q=5 on the 2nd beat of an 8-beat frame → all 8 beats pass uninterrupted; next frame held until `qcnt`=0.
- Request Q=100, then Q=0 twenty cycles later → `pause_active` low the cycle after the second strobe, pending frame flows.
- `cfg_pause_enable`=0, request Q=50 → `pause_active` stays 0, no holds. Enable dropped mid-pause → timer cleared next cycle.
- `aresetn` asserted during `HOLD` with `qcnt`=40 → all outputs at reset values asynchronously, `held_frames`=0; after release, frames pass.
